// File: rtl/oc8051_procarbiter_n.sv
// N-way arbiter sharing one memory/bus port among NPROC 8051 cores.
// Fixed-priority or round-robin selection, with a bus-hang watchdog.
module oc8051_procarbiter_n #(
   parameter int NPROC   = 4,
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int RR      = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NPROC-1:0]           stb_i,
   input  logic [NPROC-1:0]           wr_i,
   input  logic [NPROC*AW-1:0]        addr_i,
   input  logic [NPROC*DW-1:0]        data_in_i,
   input  logic [NPROC-1:0]           priv_lvl_i,
   input  logic [NPROC*16-1:0]        dpc_ot_i,
   output logic [NPROC-1:0]           ack_o,
   output logic [DW-1:0]              data_out_o,
   output logic                       stb,
   output logic                       wr,
   output logic [AW-1:0]              addr,
   output logic [DW-1:0]              data_in,
   output logic                       priv_lvl,
   output logic [15:0]                dpc_ot,
   input  logic                       ack,
   input  logic [DW-1:0]              data_out,
   output logic [$clog2(NPROC)-1:0]   sel_idx,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int IW = $clog2(NPROC);
   localparam int WW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   holder, holder_nxt;
   logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]   winner;
   logic [IW:0]     scan_sum;
   logic [WW-1:0]   wdog, wdog_nxt;
   logic            tmo_nxt;
   logic            any_stb;

   assign any_stb = |stb_i;

   // Winner: the last assignment in each loop has the highest priority.
   always_comb begin
      winner   = '0;
      scan_sum = '0;
      if (RR != 0) begin
         for (int i = NPROC; i >= 1; i--) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan_sum >= (IW+1)'(NPROC))
               scan_sum = scan_sum - (IW+1)'(NPROC);
            if (stb_i[scan_sum[IW-1:0]])
               winner = scan_sum[IW-1:0];
         end
      end else begin
         for (int i = NPROC - 1; i >= 0; i--) begin
            if (stb_i[IW'(i)])
               winner = IW'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         holder      <= '0;
         rr_ptr      <= IW'(NPROC - 1);
         wdog        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         holder      <= holder_nxt;
         rr_ptr      <= rr_ptr_nxt;
         wdog        <= wdog_nxt;
         timeout_err <= tmo_nxt;
      end
   end

   // Next-state logic; ack always takes precedence over the watchdog.
   always_comb begin
      state_nxt  = state;
      holder_nxt = holder;
      rr_ptr_nxt = rr_ptr;
      wdog_nxt   = wdog;
      tmo_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (any_stb) begin
               if (ack) begin
                  rr_ptr_nxt = winner;
               end else begin
                  holder_nxt = winner;
                  state_nxt  = BUSY;
                  wdog_nxt   = WW'(1);
               end
            end
         end
         BUSY: begin
            if (ack) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = holder;
               wdog_nxt   = '0;
            end else if (TIMEOUT != 0 && wdog == WW'(TIMEOUT)) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = holder;
               wdog_nxt   = '0;
               tmo_nxt    = 1'b1;
            end else if (wdog != '1) begin
               wdog_nxt = wdog + WW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: routing is purely combinational from the selected slice.
   always_comb begin
      busy     = (state == BUSY);
      sel_idx  = (state == BUSY || !any_stb) ? holder : winner;
      stb      = stb_i[sel_idx];
      wr       = 1'b0;
      addr     = '0;
      data_in  = '0;
      priv_lvl = 1'b0;
      dpc_ot   = '0;
      for (int k = 0; k < NPROC; k++) begin
         if (sel_idx == IW'(k)) begin
            wr       = wr_i[k];
            addr     = addr_i[k*AW +: AW];
            data_in  = data_in_i[k*DW +: DW];
            priv_lvl = priv_lvl_i[k];
            dpc_ot   = dpc_ot_i[k*16 +: 16];
         end
      end
      // An ack coinciding with reset is discarded along with the transfer.
      ack_o      = (ack && stb && !rst) ? ({{(NPROC-1){1'b0}}, 1'b1} << sel_idx) : '0;
      data_out_o = data_out;
   end

endmodule

// File: tb/tb_oc8051_procarbiter_n.sv
// Directed bench: a round-robin instance and a fixed-priority instance
// share the same request inputs; each scenario resets before it starts.
module tb_oc8051_procarbiter_n;

  localparam int NPROC = 4;
  localparam int AW    = 16;
  localparam int DW    = 8;

  logic                  clk;
  logic                  rst;
  logic [NPROC-1:0]      stb_i;
  logic [NPROC-1:0]      wr_i;
  logic [NPROC*AW-1:0]   addr_i;
  logic [NPROC*DW-1:0]   data_in_i;
  logic [NPROC-1:0]      priv_lvl_i;
  logic [NPROC*16-1:0]   dpc_ot_i;
  logic                  ack;
  logic [DW-1:0]         data_out;

  logic [NPROC-1:0]      r_ack_o, f_ack_o;
  logic [DW-1:0]         r_data_out_o, f_data_out_o;
  logic                  r_stb, f_stb, r_wr, f_wr, r_priv, f_priv;
  logic [AW-1:0]         r_addr, f_addr;
  logic [DW-1:0]         r_data_in, f_data_in;
  logic [15:0]           r_dpc, f_dpc;
  logic [1:0]            r_sel, f_sel;
  logic                  r_busy, f_busy, r_tmo, f_tmo;

  int n_checks;
  int n_fail;

  oc8051_procarbiter_n #(.NPROC(NPROC), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(4)) dut_rr (
    .clk(clk), .rst(rst), .stb_i(stb_i), .wr_i(wr_i), .addr_i(addr_i),
    .data_in_i(data_in_i), .priv_lvl_i(priv_lvl_i), .dpc_ot_i(dpc_ot_i),
    .ack_o(r_ack_o), .data_out_o(r_data_out_o), .stb(r_stb), .wr(r_wr),
    .addr(r_addr), .data_in(r_data_in), .priv_lvl(r_priv), .dpc_ot(r_dpc),
    .ack(ack), .data_out(data_out), .sel_idx(r_sel), .busy(r_busy),
    .timeout_err(r_tmo)
  );

  oc8051_procarbiter_n #(.NPROC(NPROC), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .rst(rst), .stb_i(stb_i), .wr_i(wr_i), .addr_i(addr_i),
    .data_in_i(data_in_i), .priv_lvl_i(priv_lvl_i), .dpc_ot_i(dpc_ot_i),
    .ack_o(f_ack_o), .data_out_o(f_data_out_o), .stb(f_stb), .wr(f_wr),
    .addr(f_addr), .data_in(f_data_in), .priv_lvl(f_priv), .dpc_ot(f_dpc),
    .ack(ack), .data_out(data_out), .sel_idx(f_sel), .busy(f_busy),
    .timeout_err(f_tmo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stb_i = '0;
    ack   = 1'b0;
    tick();
    rst   = 1'b0;
  endtask

  // Reset state
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (r_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", r_busy); end
    n_checks++; if (r_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %0b expected 0", r_tmo); end
    n_checks++; if (r_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", r_sel); end
    n_checks++; if (r_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %0b expected 0", r_stb); end
    n_checks++; if (r_ack_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_o: got %b expected 0000", r_ack_o); end
    tick();
  endtask

  // Single core, three wait states
  task automatic test_single();
    do_reset();
    stb_i = 4'b0001;
    ack   = 1'b0;
    @(negedge clk);
    n_checks++; if (r_sel !== 2'd0 || r_stb !== 1'b1 || r_busy !== 1'b0) begin n_fail++; $display("FAIL single_grant: sel=%0d stb=%0b busy=%0b expected 0 1 0", r_sel, r_stb, r_busy); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      ack = (c == 3);
      @(negedge clk);
      n_checks++; if (r_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c%0d: got %0b expected 1", c, r_busy); end
      n_checks++; if (r_ack_o !== ((c == 3) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_ack_o_c%0d: got %b expected %b", c, r_ack_o, (c == 3) ? 4'b0001 : 4'b0000); end
      tick();
    end
    stb_i = '0;
    ack   = 1'b0;
    @(negedge clk);
    n_checks++; if (r_busy !== 1'b0) begin n_fail++; $display("FAIL single_release: busy got %0b expected 0", r_busy); end
    tick();
  endtask

  // Round-robin rotation with zero-wait transfers
  task automatic test_rr_order();
    logic [1:0] exp_sel [5];
    logic [3:0] onehot;
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    stb_i    = 4'b1111;
    ack      = 1'b1;
    data_out = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      onehot = 4'b0001 << exp_sel[c];
      @(negedge clk);
      n_checks++; if (r_sel !== exp_sel[c]) begin n_fail++; $display("FAIL rr_sel_c%0d: got %0d expected %0d", c, r_sel, exp_sel[c]); end
      n_checks++; if (r_ack_o !== onehot) begin n_fail++; $display("FAIL rr_ack_o_c%0d: got %b expected %b", c, r_ack_o, onehot); end
      n_checks++; if (r_addr !== 16'h1000 + 16'(exp_sel[c])) begin n_fail++; $display("FAIL rr_addr_c%0d: got %h expected %h", c, r_addr, 16'h1000 + 16'(exp_sel[c])); end
      n_checks++; if (r_dpc !== 16'hD000 + 16'(exp_sel[c]) || r_data_in !== 8'hA0 + 8'(exp_sel[c])) begin n_fail++; $display("FAIL rr_route_c%0d: dpc=%h din=%h", c, r_dpc, r_data_in); end
      n_checks++; if (r_busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_c%0d: got %0b expected 0", c, r_busy); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (r_data_out_o !== 8'h5A) begin n_fail++; $display("FAIL rr_data_out: got %h expected 5a", r_data_out_o); end
    n_checks++; if (r_priv !== 1'b1 || r_wr !== 1'b0) begin n_fail++; $display("FAIL rr_priv_wr core1: priv=%0b wr=%0b expected 1 0", r_priv, r_wr); end
    tick();
  endtask

  // Fixed priority: lowest requesting index wins every time
  task automatic test_fixed_prio();
    do_reset();
    stb_i = 4'b1110;
    ack   = 1'b1;
    @(negedge clk);
    n_checks++; if (f_sel !== 2'd1 || f_ack_o !== 4'b0010) begin n_fail++; $display("FAIL fp_first: sel=%0d ack_o=%b expected 1 0010", f_sel, f_ack_o); end
    tick();
    stb_i = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (f_sel !== 2'd0 || f_ack_o !== 4'b0001) begin n_fail++; $display("FAIL fp_c%0d: sel=%0d ack_o=%b expected 0 0001", c, f_sel, f_ack_o); end
      tick();
    end
  endtask

  // Watchdog abort after 4 BUSY cycles; holder drops its strobe meanwhile
  task automatic test_timeout();
    do_reset();
    stb_i = 4'b0100;
    ack   = 1'b0;
    @(negedge clk);
    n_checks++; if (r_sel !== 2'd2 || r_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_grant: sel=%0d busy=%0b expected 2 0", r_sel, r_busy); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) stb_i = 4'b0000;
      @(negedge clk);
      n_checks++; if (r_busy !== 1'b1 || r_tmo !== 1'b0 || r_ack_o !== 4'b0000) begin n_fail++; $display("FAIL tmo_busy_c%0d: busy=%0b tmo=%0b ack_o=%b expected 1 0 0000", c, r_busy, r_tmo, r_ack_o); end
      n_checks++; if (r_stb !== (c != 4) || r_sel !== 2'd2) begin n_fail++; $display("FAIL tmo_stb_c%0d: stb=%0b sel=%0d", c, r_stb, r_sel); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (r_busy !== 1'b0 || r_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: busy=%0b tmo=%0b expected 0 1", r_busy, r_tmo); end
    tick();
    stb_i = 4'b1111;
    ack   = 1'b1;
    @(negedge clk);
    n_checks++; if (r_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_once: got %0b expected 0", r_tmo); end
    n_checks++; if (r_sel !== 2'd3) begin n_fail++; $display("FAIL tmo_rr_ptr: sel got %0d expected 3", r_sel); end
    tick();
  endtask

  // Grant held while others request; pointer advances from the holder
  task automatic test_back_to_back();
    do_reset();
    stb_i = 4'b0100;
    ack   = 1'b0;
    tick();
    stb_i = 4'b1111;
    @(negedge clk);
    n_checks++; if (r_sel !== 2'd2 || r_busy !== 1'b1 || r_ack_o !== 4'b0000) begin n_fail++; $display("FAIL hold_sel: sel=%0d busy=%0b ack_o=%b expected 2 1 0000", r_sel, r_busy, r_ack_o); end
    tick();
    ack = 1'b1;
    @(negedge clk);
    n_checks++; if (r_ack_o !== 4'b0100) begin n_fail++; $display("FAIL hold_ack: got %b expected 0100", r_ack_o); end
    tick();
    stb_i = 4'b1011;
    ack   = 1'b0;
    @(negedge clk);
    n_checks++; if (r_sel !== 2'd3 || r_busy !== 1'b0 || r_stb !== 1'b1) begin n_fail++; $display("FAIL next_winner: sel=%0d busy=%0b stb=%0b expected 3 0 1", r_sel, r_busy, r_stb); end
    tick();
  endtask

  // Reset while BUSY with a simultaneous ack
  task automatic test_reset_mid();
    do_reset();
    stb_i = 4'b1000;
    ack   = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (r_sel !== 2'd3 || r_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: sel=%0d busy=%0b expected 3 1", r_sel, r_busy); end
    tick();
    rst = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    n_checks++; if (r_ack_o !== 4'b0000) begin n_fail++; $display("FAIL mid_ack_drop: got %b expected 0000", r_ack_o); end
    tick();
    rst   = 1'b0;
    ack   = 1'b0;
    stb_i = 4'b1111;
    @(negedge clk);
    n_checks++; if (r_busy !== 1'b0 || r_tmo !== 1'b0) begin n_fail++; $display("FAIL mid_after: busy=%0b tmo=%0b expected 0 0", r_busy, r_tmo); end
    n_checks++; if (r_sel !== 2'd0) begin n_fail++; $display("FAIL mid_rr_ptr: sel got %0d expected 0", r_sel); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    stb_i    = '0;
    ack      = 1'b0;
    data_out = '0;
    wr_i       = 4'b0101;
    priv_lvl_i = 4'b1010;
    for (int k = 0; k < NPROC; k++) begin
      addr_i[k*AW +: AW]    = 16'h1000 + 16'(k);
      data_in_i[k*DW +: DW] = 8'hA0 + 8'(k);
      dpc_ot_i[k*16 +: 16]  = 16'hD000 + 16'(k);
    end
    tick();
    test_reset();
    test_single();
    test_rr_order();
    test_fixed_prio();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
